// File: rtl/i2s_capture_ctrl.sv
// rtl/i2s_capture_ctrl.sv - I2S master capturing the left-channel word of each frame into a small FIFO
module i2s_capture_ctrl #(
    parameter int CLK_DIV       = 2,
    parameter int SAMPLE_BITS   = 18,
    parameter int WARMUP_FRAMES = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   sd,
    output logic                   sck,
    output logic                   ws,
    output logic [SAMPLE_BITS-1:0] sample_data,
    output logic                   sample_valid,
    input  logic                   sample_ready,
    output logic                   overflow,
    output logic                   busy
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [7:0]    WARM_LAST = 8'(WARMUP_FRAMES - 1);
    localparam logic [5:0]    LAST_BIT  = 6'(SAMPLE_BITS);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WARMUP, CAPTURE} state_t;

    state_t                 state, state_next;
    logic [DW-1:0]          div_cnt;
    logic [5:0]             bit_cnt;
    logic [5:0]             bit_cnt_inc;
    logic [7:0]             warm_cnt;
    logic [SAMPLE_BITS-1:0] shift_reg;
    logic [SAMPLE_BITS-1:0] word;
    logic [SAMPLE_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]            wr_ptr, rd_ptr;
    logic                   tick, rise, fall, wrap;
    logic                   shift_en, push, push_ok, pop, full;

    // SCK edges are decided one cycle ahead: the registered sck flips on the same edge as the event
    always_comb begin
        tick        = (state != IDLE) && (div_cnt == '0);
        rise        = tick && !sck;
        fall        = tick && sck;
        bit_cnt_inc = bit_cnt + 6'd1;
        wrap        = fall && (bit_cnt == 6'd63);
        shift_en    = rise && (bit_cnt >= 6'd1) && (bit_cnt <= LAST_BIT);
        word        = (shift_reg << 1) | SAMPLE_BITS'(sd);
        push        = rise && (state == CAPTURE) && (bit_cnt == LAST_BIT);
        full        = (wr_ptr - rd_ptr) == FULL_CNT;
        pop         = sample_valid && sample_ready;
        push_ok     = push && (!full || pop);
        state_next  = state;
        case (state)
            IDLE: begin
                if (enable)
                    state_next = (WARMUP_FRAMES == 0) ? CAPTURE : WARMUP;
            end
            WARMUP: begin
                if (wrap && !enable)
                    state_next = IDLE;
                else if (wrap && (warm_cnt == WARM_LAST))
                    state_next = CAPTURE;
            end
            CAPTURE: begin
                if (wrap && !enable)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            warm_cnt  <= '0;
            sck       <= 1'b0;
            ws        <= 1'b0;
            shift_reg <= '0;
            overflow  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                if (enable) begin
                    div_cnt  <= DIV_LAST;
                    bit_cnt  <= '0;
                    warm_cnt <= '0;
                    sck      <= 1'b0;
                    overflow <= 1'b0;
                end
            end else begin
                if (tick) begin
                    div_cnt <= DIV_LAST;
                    sck     <= ~sck;
                end else begin
                    div_cnt <= div_cnt - 1'b1;
                end
                // The wrap lands on bit_cnt=0, so sck and ws both return low when stopping
                if (fall) begin
                    bit_cnt <= bit_cnt_inc;
                    ws      <= bit_cnt_inc[5];
                    if (wrap && (state == WARMUP))
                        warm_cnt <= warm_cnt + 8'd1;
                end
                if (shift_en)
                    shift_reg <= word;
            end
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= word;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (push && !push_ok)
                overflow <= 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign sample_data  = mem[rd_ptr[AW-1:0]];
    assign sample_valid = (wr_ptr != rd_ptr);
    assign busy         = (state != IDLE);
endmodule
